// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RV32I opcodes, instruction field positions and
// small decode helpers used by the operand fetch stage.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;

   // rs1 is read by everything except the upper-immediate forms and JAL
   function automatic logic usesRs1(input logic [6:0] opc);
      return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
   endfunction

   // rs2 is only a real source for branches, stores and register-register ops
   function automatic logic usesRs2(input logic [6:0] opc);
      return (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
   endfunction

   // Branches and stores reuse the rd field as immediate bits
   function automatic logic writesRd(input logic [6:0] opc);
      return (opc == OPC_LUI  || opc == OPC_AUIPC || opc == OPC_JAL ||
              opc == OPC_JALR || opc == OPC_LOAD  || opc == OPC_OPIMM ||
              opc == OPC_OP);
   endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-operand source select: x0 reads as zero, a same-cycle write-back
// to the addressed register is forwarded, otherwise the register file value.
module operand_bypass #(
   parameter int XLEN      = 32,
   parameter int NREG_BITS = 5
) (
   input  logic [NREG_BITS-1:0] addr_i,
   input  logic [XLEN-1:0]      rf_data_i,
   input  logic                 wb_we_i,
   input  logic [NREG_BITS-1:0] wb_wa_i,
   input  logic [XLEN-1:0]      wb_wd_i,
   output logic [XLEN-1:0]      data_o
);

   // The register file write lands on the clock edge, so a same-cycle read
   // would still return the stale value; forward the write data instead.
   always_comb begin
      data_o = rf_data_i;
      if (addr_i == '0) begin
         data_o = '0;
      end else if (wb_we_i && (wb_wa_i == addr_i)) begin
         data_o = wb_wd_i;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand fetch stage feeding the ID/EX pipeline register.
// Handles write-back bypass, load-use stalls, flush and output backpressure.
// Optional performance counters are enabled with OPFETCH_PERF_EN.
module operand_fetch #(
   parameter int XLEN      = cpu_pkg::XLEN,
   parameter int NREG_BITS = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_inst,
   input  logic [XLEN-1:0]      in_pc,
   output logic [NREG_BITS-1:0] rf_ra1,
   output logic [NREG_BITS-1:0] rf_ra2,
   input  logic [XLEN-1:0]      rf_rd1,
   input  logic [XLEN-1:0]      rf_rd2,
   input  logic                 wb_we,
   input  logic [NREG_BITS-1:0] wb_wa,
   input  logic [XLEN-1:0]      wb_wd,
   input  logic                 ex_valid,
   input  logic                 ex_is_load,
   input  logic [NREG_BITS-1:0] ex_rd,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [31:0]          out_inst,
   output logic [XLEN-1:0]      out_rs1_val,
   output logic [XLEN-1:0]      out_rs2_val,
`ifdef OPFETCH_PERF_EN
   output logic [31:0]          stall_cycles,
   output logic [31:0]          flush_count,
`endif
   output logic [NREG_BITS-1:0] out_rd
);

   import cpu_pkg::*;

   logic [6:0]           inOpc;
   logic [NREG_BITS-1:0] rs1Addr;
   logic [NREG_BITS-1:0] rs2Addr;
   logic                 inUsesRs1;
   logic                 inUsesRs2;
   logic                 hazard;
   logic                 capture;
   logic [XLEN-1:0]      rs1Fwd;
   logic [XLEN-1:0]      rs2Fwd;

   logic [NREG_BITS-1:0] heldRs1;
   logic [NREG_BITS-1:0] heldRs2;

   logic                 valid_q, valid_d;
   logic [XLEN-1:0]      pc_q, pc_d;
   logic [31:0]          inst_q, inst_d;
   logic [XLEN-1:0]      rs1Val_q, rs1Val_d;
   logic [XLEN-1:0]      rs2Val_q, rs2Val_d;
   logic [NREG_BITS-1:0] rd_q, rd_d;

   assign inOpc   = in_inst[6:0];
   assign rs1Addr = in_inst[RS1_LSB +: NREG_BITS];
   assign rs2Addr = in_inst[RS2_LSB +: NREG_BITS];
   assign rf_ra1  = rs1Addr;
   assign rf_ra2  = rs2Addr;

   assign inUsesRs1 = usesRs1(inOpc);
   assign inUsesRs2 = usesRs2(inOpc);

   assign heldRs1 = inst_q[RS1_LSB +: NREG_BITS];
   assign heldRs2 = inst_q[RS2_LSB +: NREG_BITS];

   operand_bypass #(.XLEN(XLEN), .NREG_BITS(NREG_BITS)) uBypassRs1 (
      .addr_i    (rs1Addr),
      .rf_data_i (rf_rd1),
      .wb_we_i   (wb_we),
      .wb_wa_i   (wb_wa),
      .wb_wd_i   (wb_wd),
      .data_o    (rs1Fwd)
   );

   operand_bypass #(.XLEN(XLEN), .NREG_BITS(NREG_BITS)) uBypassRs2 (
      .addr_i    (rs2Addr),
      .rf_data_i (rf_rd2),
      .wb_we_i   (wb_we),
      .wb_wa_i   (wb_wa),
      .wb_wd_i   (wb_wd),
      .data_o    (rs2Fwd)
   );

   // A load in EX cannot forward in time, so hold off any consumer of its rd
   always_comb begin
      hazard = ex_valid && ex_is_load && (ex_rd != '0) &&
               ((inUsesRs1 && (ex_rd == rs1Addr)) ||
                (inUsesRs2 && (ex_rd == rs2Addr)));
      in_ready = !flush && !hazard && (!valid_q || out_ready);
      capture  = in_valid && in_ready;
   end

   // Next-state for the ID/EX register: flush, then capture, then drain, then hold with snoop
   always_comb begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      rs1Val_d = rs1Val_q;
      rs2Val_d = rs2Val_q;
      rd_d     = rd_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d  = 1'b1;
         pc_d     = in_pc;
         inst_d   = in_inst;
         rs1Val_d = rs1Fwd;
         rs2Val_d = rs2Fwd;
         rd_d     = writesRd(inOpc) ? in_inst[RD_LSB +: NREG_BITS] : '0;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end else if (valid_q) begin
         if (wb_we && (wb_wa != '0) && (wb_wa == heldRs1) && usesRs1(inst_q[6:0])) begin
            rs1Val_d = wb_wd;
         end
         if (wb_we && (wb_wa != '0) && (wb_wa == heldRs2) && usesRs2(inst_q[6:0])) begin
            rs2Val_d = wb_wd;
         end
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         inst_q   <= '0;
         rs1Val_q <= '0;
         rs2Val_q <= '0;
         rd_q     <= '0;
      end else begin
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         rs1Val_q <= rs1Val_d;
         rs2Val_q <= rs2Val_d;
         rd_q     <= rd_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_pc      = pc_q;
   assign out_inst    = inst_q;
   assign out_rs1_val = rs1Val_q;
   assign out_rs2_val = rs2Val_q;
   assign out_rd      = rd_q;

`ifdef OPFETCH_PERF_EN
   logic [31:0] stallCnt_q;
   logic [31:0] flushCnt_q;

   // Count cycles where fetch was blocked by a hazard or backpressure, and flush cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         if (in_valid && !in_ready && !flush) begin
            stallCnt_q <= stallCnt_q + 32'd1;
         end
         if (flush) begin
            flushCnt_q <= flushCnt_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stallCnt_q;
   assign flush_count  = flushCnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch: bypass, load-use stall, held-operand
// snoop, flush and asynchronous reset. Define OPFETCH_PERF_EN to also cover the counters.
module tb_operand_fetch;

   localparam logic [31:0] INST_ADD   = 32'h002081B3; // add x3,x1,x2
   localparam logic [31:0] INST_ADD0  = 32'h002001B3; // add x3,x0,x2
   localparam logic [31:0] INST_LUI   = 32'h000080B7; // lui x1,0x8 (rs1 field = 1)
   localparam logic [31:0] INST_SW    = 32'h0020A623; // sw x2,12(x1)
   localparam logic [31:0] INST_ADD2  = 32'h004182B3; // add x5,x3,x4

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic [4:0]  rf_ra1;
   logic [4:0]  rf_ra2;
   logic [31:0] rf_rd1;
   logic [31:0] rf_rd2;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        ex_valid;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [31:0] out_rs1_val;
   logic [31:0] out_rs2_val;
   logic [4:0]  out_rd;
`ifdef OPFETCH_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   int checks = 0;
   int errors = 0;

   operand_fetch #(.XLEN(32), .NREG_BITS(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .rf_ra1      (rf_ra1),
      .rf_ra2      (rf_ra2),
      .rf_rd1      (rf_rd1),
      .rf_rd2      (rf_rd2),
      .wb_we       (wb_we),
      .wb_wa       (wb_wa),
      .wb_wd       (wb_wd),
      .ex_valid    (ex_valid),
      .ex_is_load  (ex_is_load),
      .ex_rd       (ex_rd),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_inst    (out_inst),
      .out_rs1_val (out_rs1_val),
      .out_rs2_val (out_rs2_val),
`ifdef OPFETCH_PERF_EN
      .stall_cycles(stall_cycles),
      .flush_count (flush_count),
`endif
      .out_rd      (out_rd)
   );

   // 10-unit free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present an instruction with its register file read data
   task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic [31:0] pc,
                                input logic [31:0] rd1, input logic [31:0] rd2);
      in_valid = valid;
      in_inst  = inst;
      in_pc    = pc;
      rf_rd1   = rd1;
      rf_rd2   = rd2;
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence
   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'h0;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
      flush = 1'b0; out_ready = 1'b1;

      #12;
      checkOutput("reset_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("reset_pc",    out_pc, 32'h0);
      checkOutput("reset_inst",  out_inst, 32'h0);
      checkOutput("reset_rs1",   out_rs1_val, 32'h0);
      checkOutput("reset_rs2",   out_rs2_val, 32'h0);
      checkOutput("reset_rd",    {27'b0, out_rd}, 32'h0);
      rst = 1'b0;
      tick();

      // Basic capture of add x3,x1,x2
      applyStimulus(1'b1, INST_ADD, 32'h100, 32'd5, 32'd7);
      #1;
      checkOutput("add_ready", {31'b0, in_ready}, 32'h1);
      checkOutput("add_ra1",   {27'b0, rf_ra1}, 32'd1);
      checkOutput("add_ra2",   {27'b0, rf_ra2}, 32'd2);
      tick();
      checkOutput("add_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("add_rs1",   out_rs1_val, 32'd5);
      checkOutput("add_rs2",   out_rs2_val, 32'd7);
      checkOutput("add_rd",    {27'b0, out_rd}, 32'd3);
      checkOutput("add_pc",    out_pc, 32'h100);
      checkOutput("add_inst",  out_inst, INST_ADD);

      // Write-back bypass onto rs1
      applyStimulus(1'b1, INST_ADD, 32'h104, 32'd5, 32'd7);
      wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'hAA;
      tick();
      checkOutput("byp_rs1", out_rs1_val, 32'hAA);
      checkOutput("byp_rs2", out_rs2_val, 32'd7);

      // Write-back to x0 must not be forwarded
      wb_wa = 5'd0;
      applyStimulus(1'b1, INST_ADD, 32'h108, 32'd5, 32'd7);
      tick();
      checkOutput("wbx0_rs1", out_rs1_val, 32'd5);

      // Source x0 reads zero regardless of register file data
      wb_we = 1'b0;
      applyStimulus(1'b1, INST_ADD0, 32'h10C, 32'h99, 32'd7);
      tick();
      checkOutput("x0_rs1", out_rs1_val, 32'h0);
      checkOutput("x0_rs2", out_rs2_val, 32'd7);

      // Load-use on rs1 stalls and drains a bubble
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
      applyStimulus(1'b1, INST_ADD, 32'h110, 32'd5, 32'd7);
      #1;
      checkOutput("luse_ready", {31'b0, in_ready}, 32'h0);
      tick();
      checkOutput("luse_bubble", {31'b0, out_valid}, 32'h0);

      // Load leaves EX, instruction accepted
      ex_valid = 1'b0;
      #1;
      checkOutput("luse_release_ready", {31'b0, in_ready}, 32'h1);
      tick();
      checkOutput("luse_release_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("luse_release_pc",    out_pc, 32'h110);

      // LUI ignores its rs1 field, so no stall
      ex_valid = 1'b1; ex_rd = 5'd1;
      applyStimulus(1'b1, INST_LUI, 32'h114, 32'd5, 32'd7);
      #1;
      checkOutput("lui_ready", {31'b0, in_ready}, 32'h1);
      tick();
      checkOutput("lui_inst", out_inst, INST_LUI);
      checkOutput("lui_rd",   {27'b0, out_rd}, 32'd1);

      // Load-use on rs2
      ex_rd = 5'd2;
      applyStimulus(1'b1, INST_ADD, 32'h118, 32'd5, 32'd7);
      #1;
      checkOutput("luse2_ready", {31'b0, in_ready}, 32'h0);
      tick();
      checkOutput("luse2_bubble", {31'b0, out_valid}, 32'h0);

      // Store writes no register
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
      applyStimulus(1'b1, INST_SW, 32'h11C, 32'd5, 32'd7);
      tick();
      checkOutput("sw_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("sw_rd",    {27'b0, out_rd}, 32'd0);
      checkOutput("sw_rs2",   out_rs2_val, 32'd7);

      // Capture add x5,x3,x4 then hold it under backpressure
      applyStimulus(1'b1, INST_ADD2, 32'h120, 32'h33, 32'h44);
      tick();
      checkOutput("hold_cap_rs2", out_rs2_val, 32'h44);
      checkOutput("hold_cap_rd",  {27'b0, out_rd}, 32'd5);

      out_ready = 1'b0;
      applyStimulus(1'b1, INST_ADD, 32'h124, 32'd5, 32'd7);
      #1;
      checkOutput("hold1_ready", {31'b0, in_ready}, 32'h0);
      tick();
      checkOutput("hold1_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("hold1_rs2",   out_rs2_val, 32'h44);

      wb_we = 1'b1; wb_wa = 5'd4; wb_wd = 32'h1234;
      #1;
      checkOutput("hold2_ready", {31'b0, in_ready}, 32'h0);
      tick();
      checkOutput("hold2_rs2", out_rs2_val, 32'h1234);
      checkOutput("hold2_pc",  out_pc, 32'h120);

      wb_we = 1'b0;
      #1;
      checkOutput("hold3_ready", {31'b0, in_ready}, 32'h0);
      tick();
      checkOutput("hold3_rs2", out_rs2_val, 32'h1234);
      checkOutput("hold3_rs1", out_rs1_val, 32'h33);

      out_ready = 1'b1;
      #1;
      checkOutput("release_rs2",   out_rs2_val, 32'h1234);
      checkOutput("release_ready", {31'b0, in_ready}, 32'h1);
      tick();
      checkOutput("release_pc", out_pc, 32'h124);

      // Flush wins over a simultaneous out_ready
      flush = 1'b1;
      applyStimulus(1'b1, INST_ADD, 32'h128, 32'd5, 32'd7);
      #1;
      checkOutput("flush_ready", {31'b0, in_ready}, 32'h0);
      tick();
      checkOutput("flush_valid", {31'b0, out_valid}, 32'h0);
`ifdef OPFETCH_PERF_EN
      checkOutput("flush_count",  flush_count, 32'd1);
      checkOutput("stall_cycles", stall_cycles, 32'd5);
`endif
      flush = 1'b0;

      // Asynchronous reset while holding
      applyStimulus(1'b1, INST_ADD, 32'h12C, 32'd5, 32'd7);
      tick();
      out_ready = 1'b0;
      applyStimulus(1'b0, INST_ADD, 32'h130, 32'd5, 32'd7);
      tick();
      checkOutput("prerst_valid", {31'b0, out_valid}, 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("arst_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("arst_pc",    out_pc, 32'h0);
      checkOutput("arst_inst",  out_inst, 32'h0);
      checkOutput("arst_rs1",   out_rs1_val, 32'h0);
      checkOutput("arst_rs2",   out_rs2_val, 32'h0);
      checkOutput("arst_rd",    {27'b0, out_rd}, 32'h0);
`ifdef OPFETCH_PERF_EN
      checkOutput("arst_flush_count", flush_count, 32'd0);
`endif
      tick();
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage directly upstream of the EX stage; drives the register file's asynchronous read addresses and consumes its read data.
- Applies write-back bypass, because the register file's synchronous write is not visible to a same-cycle read.
- Detects load-use hazards against EX.
- Registers instruction plus operands into the ID/EX pipeline register under a valid/ready handshake with stall and flush.

Parameters:
- XLEN, 32, data/PC width
- NREG_BITS, 5, register address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_inst  in  32  RV32I instruction word
- in_pc  in  XLEN  instruction PC
- rf_ra1  out  NREG_BITS  register file read address 1 = in_inst[19:15]
- rf_ra2  out  NREG_BITS  register file read address 2 = in_inst[24:20]
- rf_rd1  in  XLEN  register file read data 1
- rf_rd2  in  XLEN  register file read data 2
- wb_we  in  1  write-back write enable (same signal as register file write enable)
- wb_wa  in  NREG_BITS  write-back destination
- wb_wd  in  XLEN  write-back data
- ex_valid  in  1  EX holds a valid instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  NREG_BITS  EX destination register
- flush  in  1  squash stage contents (branch/jump redirect)
- out_valid  out  1  ID/EX register valid
- out_ready  in  1  EX accepts
- out_pc  out  XLEN  registered PC
- out_inst  out  32  registered instruction
- out_rs1_val  out  XLEN  registered operand 1
- out_rs2_val  out  XLEN  registered operand 2
- out_rd  out  NREG_BITS  registered in_inst[11:7]; 0 if the opcode writes no register

Behaviour:
- Reset: out_valid=0; out_pc, out_inst, out_rs1_val, out_rs2_val, out_rd = 0. Counters (if present) = 0.
- rf_ra1/rf_ra2 are driven combinationally from in_inst every cycle, regardless of in_valid.
- uses_rs1: 0 for LUI, AUIPC, JAL; else 1. uses_rs2: 1 only for BRANCH, STORE, OP. Decode is by opcode in_inst[6:0].
- Bypass, per operand:
  - Address 0 always yields 0.
  - Else if wb_we && wb_wa==addr, yield wb_wd.
  - Else yield rf_rd.
- Hazard: ex_valid && ex_is_load && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)).
- Capture condition: in_valid && in_ready. in_ready = !flush && !hazard && (!out_valid || out_ready).
- Latency: 1 cycle from accept to out_valid.
- Next-state priority, highest first:
  1. flush: out_valid<=0; nothing captured; in_ready=0 in that cycle.
  2. capture: register all outputs; out_valid<=1.
  3. out_valid && out_ready with no capture: out_valid<=0 (bubble toward EX). This covers a hazard cycle, which inserts exactly one bubble per stalled cycle.
  4. Hold: all outputs are kept, except for held-operand snoop.
- Held-operand snoop: while out_valid && !out_ready, if wb_we && wb_wa!=0 && wb_wa==out_inst rs1 (and uses_rs1), out_rs1_val<=wb_wd. Same rule for rs2. This keeps held operands coherent with later write-backs.
- Simultaneous flush and out_ready: flush wins; the entry is dropped.
- Reset asserted mid-stall clears out_valid immediately (asynchronous). The instruction is lost; fetch restarts from its own reset.
- Pure pipeline register; no FSM beyond the valid bit. Throughput is 1 instruction/cycle absent hazards and backpressure.

Optional Feature:
- Macro OPFETCH_PERF_EN.
- With the macro: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each cycle in_valid && !in_ready && !flush.
  - flush_count increments each cycle flush=1.
  - Both wrap at 2^32 and reset to 0.
- Without the macro: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP);
  - field-position constants (RS1_LSB=15, RS2_LSB=20, RD_LSB=7);
  - XLEN.
- One combinational sub-module, operand_bypass: zero-register check plus WB forward mux. It is instantiated twice, once per operand.

Test Plan:
- Reset then `add x3,x1,x2` with rf_rd1=5, rf_rd2=7, out_ready=1 -> next cycle out_valid=1, out_rs1_val=5, out_rs2_val=7, out_rd=3.
- Same instruction with wb_we=1, wb_wa=1, wb_wd=0xAA in the capture cycle -> out_rs1_val=0xAA despite rf_rd1=5; with wb_wa=0, wb_wd ignored and rf value used.
- ex_valid=1, ex_is_load=1, ex_rd=1, in_inst reads x1 -> in_ready=0 and one bubble (out_valid=0). Next cycle with ex_valid=0 -> accepted. Same case with `lui x1` in_inst -> no stall.
- out_ready=0 for 3 cycles holding an instruction with rs2=x4; wb writes x4=0x1234 in cycle 2 -> out_rs2_val=0x1234 when out_ready rises. in_ready=0 throughout.
- flush=1 while out_valid=1 and out_ready=1 -> out_valid=0 next cycle; in_ready=0 during the flush cycle; with OPFETCH_PERF_EN, flush_count=1.
- rst pulsed mid-hold -> out_valid drops the same cycle without a clock edge; all outputs 0.
